multicycle_controller: RTL and testbench

//  Multi-cycle FSM controller for the RV32I(C) core. Replaces single-cycle control for memories with variable latency.

---
 rtl/multicycle_controller.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RV32I(C) core: sequences FETCH/DECODE/EXEC/MEM/TRAP,
// handshakes imem/dmem with req/ack, traps illegal encodings and bus timeouts, counts retirements.
module multicycle_controller #(
    parameter int ACK_TIMEOUT = 16,
    parameter int TMO_W       = 5,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           opcode,
    input  logic [2:0]           func3,
    input  logic                 func7_5th_bit,
    input  logic                 c_inst_flag,
    input  logic                 br_eq,
    input  logic                 br_lt,
    input  logic                 imem_ack,
    input  logic                 dmem_ack,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic [2:0]           imm_sel,
    output logic                 reg_we,
    output logic                 br_un,
    output logic                 A_sel,
    output logic                 B_sel,
    output logic [3:0]           alu_sel,
    output logic                 data_mem_we,
    output logic [1:0]           wb_sel,
    output logic [2:0]           mode,
    output logic                 illegal_inst,
    output logic                 bus_err,
    output logic                 retire,
    output logic [INSTRET_W-1:0] instret,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_TRAP   = 3'd4
    } state_t;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_REG    = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    localparam int               TMO_LAST_I = (ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1;
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_LAST_I[TMO_W-1:0];

    state_t                 state_q, state_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   bus_cause_q, bus_cause_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;

    logic       legal, is_load, is_store, is_branch, is_jump, writes_rd, br_taken;
    logic [2:0] imm_dec, mode_dec;
    logic [3:0] alu_dec;
    logic [1:0] wb_dec, step_sel;
    logic       a_dec, b_dec, brun_dec, sel_en, tmo_hit;

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7b, input logic is_reg);
        case (f3)
            3'b000:  alu_op = (is_reg && f7b) ? 4'd1 : 4'd0;
            3'b001:  alu_op = 4'd5;
            3'b010:  alu_op = 4'd8;
            3'b011:  alu_op = 4'd9;
            3'b100:  alu_op = 4'd2;
            3'b101:  alu_op = f7b ? 4'd7 : 4'd6;
            3'b110:  alu_op = 4'd3;
            default: alu_op = 4'd4;
        endcase
    endfunction

    // Decode straight from the IR fields; only the FSM decides whether it is used.
    always_comb begin
        legal     = 1'b1;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        writes_rd = 1'b0;
        imm_dec   = 3'd0;
        a_dec     = 1'b0;
        b_dec     = 1'b0;
        alu_dec   = 4'd0;
        wb_dec    = 2'd1;
        mode_dec  = 3'd0;
        brun_dec  = 1'b0;
        case (opcode)
            OP_REG: begin
                writes_rd = 1'b1;
                alu_dec   = alu_op(func3, func7_5th_bit, 1'b1);
                legal     = !func7_5th_bit || (func3 == 3'b000) || (func3 == 3'b101);
            end
            OP_IMM: begin
                writes_rd = 1'b1;
                b_dec     = 1'b1;
                alu_dec   = alu_op(func3, func7_5th_bit, 1'b0);
                imm_dec   = (func3 == 3'b101 && func7_5th_bit) ? 3'd1 : 3'd0;
            end
            OP_LOAD: begin
                is_load = 1'b1;
                b_dec   = 1'b1;
                wb_dec  = 2'd0;
                case (func3)
                    3'b000:  mode_dec = 3'd2;
                    3'b001:  mode_dec = 3'd1;
                    3'b010:  mode_dec = 3'd0;
                    3'b100:  mode_dec = 3'd3;
                    3'b101:  mode_dec = 3'd4;
                    default: legal    = 1'b0;
                endcase
            end
            OP_STORE: begin
                is_store = 1'b1;
                imm_dec  = 3'd2;
                b_dec    = 1'b1;
                case (func3)
                    3'b000:  mode_dec = 3'd2;
                    3'b001:  mode_dec = 3'd1;
                    3'b010:  mode_dec = 3'd0;
                    default: legal    = 1'b0;
                endcase
            end
            OP_BRANCH: begin
                is_branch = 1'b1;
                imm_dec   = 3'd3;
                a_dec     = 1'b1;
                b_dec     = 1'b1;
                brun_dec  = func3[1];
                legal     = (func3 != 3'b010) && (func3 != 3'b011);
            end
            OP_JAL: begin
                is_jump   = 1'b1;
                writes_rd = 1'b1;
                imm_dec   = 3'd5;
                a_dec     = 1'b1;
                b_dec     = 1'b1;
                wb_dec    = 2'd2;
            end
            OP_JALR: begin
                is_jump   = 1'b1;
                writes_rd = 1'b1;
                b_dec     = 1'b1;
                wb_dec    = 2'd2;
            end
            OP_LUI: begin
                writes_rd = 1'b1;
                imm_dec   = 3'd4;
                b_dec     = 1'b1;
                alu_dec   = 4'd10;
            end
            OP_AUIPC: begin
                writes_rd = 1'b1;
                imm_dec   = 3'd4;
                a_dec     = 1'b1;
                b_dec     = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        case (func3)
            3'b000:         br_taken = br_eq;
            3'b001:         br_taken = !br_eq;
            3'b100, 3'b110: br_taken = br_lt;
            3'b101, 3'b111: br_taken = !br_lt;
            default:        br_taken = 1'b0;
        endcase
    end

    assign step_sel = c_inst_flag ? 2'd0 : 2'd1;
    assign tmo_hit  = (ACK_TIMEOUT != 0) && (tmo_q == TMO_LAST);

    // Everything is forced low while rst_n is asserted so requests drop without waiting for a clock.
    always_comb begin
        state_d      = state_q;
        bus_cause_d  = bus_cause_q;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        reg_we       = 1'b0;
        data_mem_we  = 1'b0;
        illegal_inst = 1'b0;
        bus_err      = 1'b0;
        retire       = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_we   = 1'b1;
                        state_d = S_DECODE;
                    end else if (tmo_hit) begin
                        bus_cause_d = 1'b1;
                        state_d     = S_TRAP;
                    end
                end
                S_DECODE: begin
                    bus_cause_d = 1'b0;
                    state_d     = legal ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    if (is_load || is_store) begin
                        state_d = S_MEM;
                    end else begin
                        pc_we   = 1'b1;
                        reg_we  = writes_rd;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                        if (is_branch)    pc_sel = br_taken ? 2'd2 : step_sel;
                        else if (is_jump) pc_sel = 2'd2;
                        else              pc_sel = step_sel;
                    end
                end
                S_MEM: begin
                    dmem_req    = 1'b1;
                    data_mem_we = is_store;
                    if (dmem_ack) begin
                        reg_we  = is_load;
                        pc_we   = 1'b1;
                        pc_sel  = step_sel;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else if (tmo_hit) begin
                        bus_cause_d = 1'b1;
                        state_d     = S_TRAP;
                    end
                end
                S_TRAP: begin
                    pc_we        = 1'b1;
                    pc_sel       = 2'd3;
                    illegal_inst = !bus_cause_q;
                    bus_err      = bus_cause_q;
                    state_d      = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    // Wait counter restarts on every state change; only FETCH/MEM can stay put.
    always_comb begin
        if (state_d != state_q)
            tmo_d = '0;
        else if (state_q == S_FETCH || state_q == S_MEM)
            tmo_d = tmo_q + 1'b1;
        else
            tmo_d = tmo_q;
        instret_d = retire ? instret_q + 1'b1 : instret_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            tmo_q       <= '0;
            bus_cause_q <= 1'b0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            bus_cause_q <= bus_cause_d;
            instret_q   <= instret_d;
        end
    end

    assign sel_en  = rst_n && (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM);
    assign imm_sel = sel_en ? imm_dec  : 3'd0;
    assign A_sel   = sel_en ? a_dec    : 1'b0;
    assign B_sel   = sel_en ? b_dec    : 1'b0;
    assign alu_sel = sel_en ? alu_dec  : 4'd0;
    assign wb_sel  = sel_en ? wb_dec   : 2'd0;
    assign mode    = sel_en ? mode_dec : 3'd0;
    assign br_un   = sel_en ? brun_dec : 1'b0;
    assign instret = instret_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected strobe vectors are queued as
// stimulus is driven and compared against the DUT mid-cycle.
module tb_multicycle_controller;

    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    opcode;
    logic [2:0]    func3;
    logic          func7_5th_bit, c_inst_flag, br_eq, br_lt, imem_ack, dmem_ack;
    logic          imem_req, dmem_req, ir_we, pc_we, reg_we, br_un, A_sel, B_sel;
    logic          data_mem_we, illegal_inst, bus_err, retire;
    logic [1:0]    pc_sel, wb_sel;
    logic [2:0]    imm_sel, mode, state;
    logic [3:0]    alu_sel;
    logic [IW-1:0] instret;

    int checks = 0;
    int errors = 0;
    logic [13:0] sb[$];
    logic [13:0] E_FA, E_FW, E_DEC, E_EX0, E_MW;

    multicycle_controller #(.ACK_TIMEOUT(16), .TMO_W(5), .INSTRET_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7_5th_bit(func7_5th_bit),
        .c_inst_flag(c_inst_flag), .br_eq(br_eq), .br_lt(br_lt), .imem_ack(imem_ack),
        .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel), .reg_we(reg_we), .br_un(br_un),
        .A_sel(A_sel), .B_sel(B_sel), .alu_sel(alu_sel), .data_mem_we(data_mem_we),
        .wb_sel(wb_sel), .mode(mode), .illegal_inst(illegal_inst), .bus_err(bus_err),
        .retire(retire), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {state, imem_req, dmem_req, ir_we, pc_we, pc_sel, reg_we, data_mem_we, retire, illegal_inst, bus_err}
    function automatic logic [13:0] ex(input int st, input bit ir, input bit dr, input bit iw, input bit pw,
                                       input int ps, input bit rw, input bit dw, input bit rt,
                                       input bit il, input bit be);
        return {3'(st), ir, dr, iw, pw, 2'(ps), rw, dw, rt, il, be};
    endfunction

    function automatic logic [13:0] obs();
        return {state, imem_req, dmem_req, ir_we, pc_we, pc_sel, reg_we, data_mem_we, retire,
                illegal_inst, bus_err};
    endfunction

    task automatic set_ir(input logic [4:0] op, input logic [2:0] f3, input logic f7b,
                          input logic c, input logic eq, input logic lt);
        opcode = op; func3 = f3; func7_5th_bit = f7b; c_inst_flag = c; br_eq = eq; br_lt = lt;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        set_ir(5'b01100, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) next_cycle();
        checks++;
        if (obs() !== 14'd0) begin
            errors++; $display("FAIL reset_outputs: got %b want %b", obs(), 14'd0);
        end
        checks++;
        if (instret !== '0) begin
            errors++; $display("FAIL reset_instret: got %0d want 0", instret);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs() !== E_FW) begin
            errors++; $display("FAIL reset_release: got %b want %b", obs(), E_FW);
        end
    endtask

    task automatic test_alu();
        logic [13:0] plan[3];
        logic [13:0] e;
        set_ir(5'b01100, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        plan[0] = E_FA; plan[1] = E_DEC; plan[2] = ex(2, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            imem_ack = (i == 0); dmem_ack = 1'b0;
            sb.push_back(plan[i]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs() !== e) begin
                errors++; $display("FAIL alu_c%0d: got %b want %b", i, obs(), e);
            end
            if (i == 2) begin
                checks++;
                if (alu_sel !== 4'd0 || wb_sel !== 2'd1 || B_sel !== 1'b0) begin
                    errors++; $display("FAIL alu_sels: got alu=%0d wb=%0d B=%0d want 0 1 0", alu_sel, wb_sel, B_sel);
                end
            end
            next_cycle();
        end
        imem_ack = 1'b0;
        checks++;
        if (instret !== 32'd1) begin
            errors++; $display("FAIL alu_instret: got %0d want 1", instret);
        end
    endtask

    task automatic test_branch();
        logic [2:0]  bf3[4] = '{3'b000, 3'b000, 3'b111, 3'b101};
        logic        bc[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic        beq[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic        blt[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int          bps[4] = '{2, 0, 1, 2};
        logic        bun[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [13:0] plan[3];
        logic [13:0] e;
        logic [IW-1:0] base;
        base = instret;
        for (int j = 0; j < 4; j++) begin
            set_ir(5'b11000, bf3[j], 1'b0, bc[j], beq[j], blt[j]);
            plan[0] = E_FA; plan[1] = E_DEC; plan[2] = ex(2, 0, 0, 0, 1, bps[j], 0, 0, 1, 0, 0);
            for (int i = 0; i < 3; i++) begin
                imem_ack = (i == 0); dmem_ack = 1'b0;
                sb.push_back(plan[i]);
                @(negedge clk);
                e = sb.pop_front(); checks++;
                if (obs() !== e) begin
                    errors++; $display("FAIL branch%0d_c%0d: got %b want %b", j, i, obs(), e);
                end
                if (i == 2) begin
                    checks++;
                    if (br_un !== bun[j] || imm_sel !== 3'd3 || A_sel !== 1'b1) begin
                        errors++; $display("FAIL branch%0d_sels: got br_un=%0d imm=%0d A=%0d want %0d 3 1",
                                           j, br_un, imm_sel, A_sel, bun[j]);
                    end
                end
                next_cycle();
            end
        end
        imem_ack = 1'b0;
        checks++;
        if (instret !== base + 32'd4) begin
            errors++; $display("FAIL branch_instret: got %0d want %0d", instret, base + 32'd4);
        end
    endtask

    task automatic test_load();
        logic [13:0] plan[7];
        logic [13:0] e;
        logic [IW-1:0] base;
        base = instret;
        set_ir(5'b00000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        plan[0] = E_FA; plan[1] = E_DEC; plan[2] = E_EX0;
        plan[3] = E_MW; plan[4] = E_MW; plan[5] = E_MW;
        plan[6] = ex(3, 0, 1, 0, 1, 1, 1, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            imem_ack = (i == 0); dmem_ack = (i == 6);
            sb.push_back(plan[i]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs() !== e) begin
                errors++; $display("FAIL load_c%0d: got %b want %b", i, obs(), e);
            end
            if (i >= 3) begin
                checks++;
                if (mode !== 3'd0 || wb_sel !== 2'd0) begin
                    errors++; $display("FAIL load_sels_c%0d: got mode=%0d wb=%0d want 0 0", i, mode, wb_sel);
                end
            end
            next_cycle();
        end
        imem_ack = 1'b0; dmem_ack = 1'b0;
        checks++;
        if (instret !== base + 32'd1) begin
            errors++; $display("FAIL load_instret: got %0d want %0d", instret, base + 32'd1);
        end
    endtask

    task automatic test_store();
        logic [13:0] plan[4];
        logic [13:0] e;
        set_ir(5'b01000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        plan[0] = E_FA; plan[1] = E_DEC; plan[2] = E_EX0;
        plan[3] = ex(3, 0, 1, 0, 1, 1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            imem_ack = (i == 0); dmem_ack = (i == 3);
            sb.push_back(plan[i]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs() !== e) begin
                errors++; $display("FAIL store_c%0d: got %b want %b", i, obs(), e);
            end
            if (i == 3) begin
                checks++;
                if (mode !== 3'd2 || imm_sel !== 3'd2) begin
                    errors++; $display("FAIL store_sels: got mode=%0d imm=%0d want 2 2", mode, imm_sel);
                end
            end
            next_cycle();
        end
        imem_ack = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic test_illegal();
        logic [4:0]  iop[2] = '{5'b11111, 5'b00000};
        logic [2:0]  if3[2] = '{3'b000, 3'b011};
        logic [13:0] plan[3];
        logic [13:0] e;
        logic [IW-1:0] base;
        base = instret;
        for (int j = 0; j < 2; j++) begin
            set_ir(iop[j], if3[j], 1'b0, 1'b0, 1'b0, 1'b0);
            plan[0] = E_FA; plan[1] = E_DEC; plan[2] = ex(4, 0, 0, 0, 1, 3, 0, 0, 0, 1, 0);
            for (int i = 0; i < 3; i++) begin
                imem_ack = (i == 0); dmem_ack = 1'b0;
                sb.push_back(plan[i]);
                @(negedge clk);
                e = sb.pop_front(); checks++;
                if (obs() !== e) begin
                    errors++; $display("FAIL illegal%0d_c%0d: got %b want %b", j, i, obs(), e);
                end
                next_cycle();
            end
        end
        imem_ack = 1'b0;
        checks++;
        if (instret !== base) begin
            errors++; $display("FAIL illegal_instret: got %0d want %0d", instret, base);
        end
    endtask

    task automatic test_timeout();
        logic [13:0] e, want;
        int n;
        set_ir(5'b01100, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n = (k == 0) ? 17 : 18;
            for (int i = 0; i < n; i++) begin
                if (k == 0) want = (i < 16) ? E_FW : ex(4, 0, 0, 0, 1, 3, 0, 0, 0, 0, 1);
                else if (i < 15) want = E_FW;
                else if (i == 15) want = E_FA;
                else if (i == 16) want = E_DEC;
                else want = ex(2, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0);
                imem_ack = (k == 1 && i == 15); dmem_ack = 1'b0;
                sb.push_back(want);
                @(negedge clk);
                e = sb.pop_front(); checks++;
                if (obs() !== e) begin
                    errors++; $display("FAIL timeout%0d_c%0d: got %b want %b", k, i, obs(), e);
                end
                next_cycle();
            end
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0]  bop[2] = '{5'b01100, 5'b01101};
        logic        bcf[2] = '{1'b1, 1'b0};
        int          bps[2] = '{0, 1};
        logic [3:0]  balu[2] = '{4'd0, 4'd10};
        logic [13:0] plan[3];
        logic [13:0] e;
        logic [IW-1:0] base;
        base = instret;
        for (int j = 0; j < 2; j++) begin
            set_ir(bop[j], 3'b000, 1'b0, bcf[j], 1'b0, 1'b0);
            plan[0] = E_FA; plan[1] = E_DEC; plan[2] = ex(2, 0, 0, 0, 1, bps[j], 1, 0, 1, 0, 0);
            for (int i = 0; i < 3; i++) begin
                imem_ack = (i == 0); dmem_ack = 1'b0;
                sb.push_back(plan[i]);
                @(negedge clk);
                e = sb.pop_front(); checks++;
                if (obs() !== e) begin
                    errors++; $display("FAIL b2b%0d_c%0d: got %b want %b", j, i, obs(), e);
                end
                if (i == 2) begin
                    checks++;
                    if (alu_sel !== balu[j]) begin
                        errors++; $display("FAIL b2b%0d_alu: got %0d want %0d", j, alu_sel, balu[j]);
                    end
                end
                next_cycle();
            end
        end
        imem_ack = 1'b0;
        checks++;
        if (instret !== base + 32'd2) begin
            errors++; $display("FAIL b2b_instret: got %0d want %0d", instret, base + 32'd2);
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] plan[4];
        logic [13:0] e;
        set_ir(5'b00000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        plan[0] = E_FA; plan[1] = E_DEC; plan[2] = E_EX0; plan[3] = E_MW;
        for (int i = 0; i < 4; i++) begin
            imem_ack = (i == 0); dmem_ack = 1'b0;
            sb.push_back(plan[i]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs() !== e) begin
                errors++; $display("FAIL rstmid_c%0d: got %b want %b", i, obs(), e);
            end
            if (i < 3) next_cycle();
        end
        imem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || dmem_req !== 1'b0 || state !== 3'd0 || instret !== '0) begin
            errors++; $display("FAIL rstmid_async: got ireq=%0d dreq=%0d state=%0d instret=%0d want 0 0 0 0",
                               imem_req, dmem_req, state, instret);
        end
        next_cycle();
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs() !== E_FW || instret !== '0) begin
            errors++; $display("FAIL rstmid_release: got %b/%0d want %b/0", obs(), instret, E_FW);
        end
    endtask

    initial begin
        E_FA  = ex(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        E_FW  = ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_DEC = ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_EX0 = ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_MW  = ex(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_alu();
        test_branch();
        test_load();
        test_store();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
